des_key_scheduler: RTL and testbench

- Sequences the DES key schedule for the round datapath: accepts a 64-bit key and applies PC-1, then per round applies the C/D rotations and PC-2.
- Presents one 48-bit subkey per round under a valid/ready handshake to the DES round engine.
- Supports encrypt order (K1..K16) and decrypt order (K16..K1).
- Sits between the key-load interface (3DES key sequencer) and the round engine.

---
 rtl/des_pkg.sv | 48 ++++
 rtl/des_key_pc1.sv | 14 +
 rtl/des_key_scheduler.sv | 160 ++++++++++++++++
 tb/tb_des_key_scheduler.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/des_pkg.sv
// Shared DES key-schedule constants: PC-1/PC-2 selection tables, rotation
// schedule, scheduler state type and the PC-2 compression helper.
package des_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    PRESENT
  } state_e;

  // Table entries are 1-based DES bit numbers, exactly as printed in FIPS 46.
  localparam logic [5:0] PC1_TAB [56] = '{
    6'd57, 6'd49, 6'd41, 6'd33, 6'd25, 6'd17, 6'd9,
    6'd1,  6'd58, 6'd50, 6'd42, 6'd34, 6'd26, 6'd18,
    6'd10, 6'd2,  6'd59, 6'd51, 6'd43, 6'd35, 6'd27,
    6'd19, 6'd11, 6'd3,  6'd60, 6'd52, 6'd44, 6'd36,
    6'd63, 6'd55, 6'd47, 6'd39, 6'd31, 6'd23, 6'd15,
    6'd7,  6'd62, 6'd54, 6'd46, 6'd38, 6'd30, 6'd22,
    6'd14, 6'd6,  6'd61, 6'd53, 6'd45, 6'd37, 6'd29,
    6'd21, 6'd13, 6'd5,  6'd28, 6'd20, 6'd12, 6'd4
  };

  localparam logic [5:0] PC2_TAB [48] = '{
    6'd14, 6'd17, 6'd11, 6'd24, 6'd1,  6'd5,
    6'd3,  6'd28, 6'd15, 6'd6,  6'd21, 6'd10,
    6'd23, 6'd19, 6'd12, 6'd4,  6'd26, 6'd8,
    6'd16, 6'd7,  6'd27, 6'd20, 6'd13, 6'd2,
    6'd41, 6'd52, 6'd31, 6'd37, 6'd47, 6'd55,
    6'd30, 6'd40, 6'd51, 6'd45, 6'd33, 6'd48,
    6'd44, 6'd49, 6'd39, 6'd56, 6'd34, 6'd53,
    6'd46, 6'd42, 6'd50, 6'd36, 6'd29, 6'd32
  };

  // Left-rotation amount for rounds 1..16 (stored 0-based).
  localparam logic [1:0] SHIFT_TAB [16] = '{
    2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
    2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1
  };

  function automatic logic [0:47] pc2(input logic [0:27] c, input logic [0:27] d);
    logic [0:55] cd;
    logic [0:47] k;
    cd = {c, d};
    for (int i = 0; i < 48; i++) k[i] = cd[PC2_TAB[i] - 6'd1];
    return k;
  endfunction

endpackage

// File: rtl/des_key_pc1.sv
// Combinational DES Permuted Choice 1: drops the eight parity bits and
// reorders the 64-bit key into the 56-bit C||D register image.
module des_key_pc1
  import des_pkg::*;
(
  input  logic [0:63] key_i,
  output logic [0:55] cd_o
);

  for (genvar i = 0; i < 56; i++) begin : g_pc1
    assign cd_o[i] = key_i[PC1_TAB[i] - 6'd1];
  end

endmodule

// File: rtl/des_key_scheduler.sv
// DES key schedule sequencer: latches PC-1 of a key, then emits one PC-2
// subkey per round (K1..K16 or K16..K1) under a valid/ready handshake.
module des_key_scheduler
  import des_pkg::*;
#(
  parameter int PARITY_CHECK = 0
) (
  input  logic        clk,
  input  logic        n_rst,
  input  logic [0:63] key_in,
  input  logic        decrypt,
  input  logic        key_valid,
  output logic        key_ready,
  input  logic        abort,
  output logic [0:47] subkey,
  output logic [3:0]  round,
  output logic        subkey_valid,
  input  logic        subkey_ready,
  output logic        sched_done,
  output logic        key_err
);

  state_e      state_q;
  logic [0:27] c_q, d_q;
  logic [3:0]  round_q;
  logic        mode_q;
  logic        key_ready_q;
  logic        subkey_valid_q;
  logic [0:47] subkey_q;
  logic        sched_done_q;
  logic        key_err_q;

  logic [0:55] pc1_cd;
  logic        parity_ok;
  logic        key_bad;
  logic [3:0]  dec_idx;
  logic [1:0]  rot_amt;
  logic [0:27] c_d, d_d;

  des_key_pc1 u_pc1 (
    .key_i (key_in),
    .cd_o  (pc1_cd)
  );

  // NOTE: every variable assigned in always_comb gets a default first, so no
  // path can leave it unassigned and infer a latch.
  always_comb begin
    parity_ok = 1'b1;
    for (int b = 0; b < 8; b++) begin
      if (!(^key_in[8*b +: 8])) parity_ok = 1'b0;
    end
  end

  assign key_bad = (PARITY_CHECK != 0) && !parity_ok;

  // Decrypt walks the encrypt schedule backwards: undo round 18-n's shift,
  // i.e. table index 16-round, which wraps neatly in 4 bits.
  assign dec_idx = 4'd0 - round_q;
  assign rot_amt = mode_q ? SHIFT_TAB[dec_idx] : SHIFT_TAB[round_q];

  always_comb begin
    c_d = c_q;
    d_d = d_q;
    if (!mode_q) begin
      if (rot_amt == 2'd2) begin
        c_d = {c_q[2:27], c_q[0:1]};
        d_d = {d_q[2:27], d_q[0:1]};
      end else begin
        c_d = {c_q[1:27], c_q[0]};
        d_d = {d_q[1:27], d_q[0]};
      end
    end else if (round_q != 4'd0) begin
      if (rot_amt == 2'd2) begin
        c_d = {c_q[26:27], c_q[0:25]};
        d_d = {d_q[26:27], d_q[0:25]};
      end else begin
        c_d = {c_q[27], c_q[0:26]};
        d_d = {d_q[27], d_q[0:26]};
      end
    end
  end

  // NOTE: state and registered outputs use non-blocking assignments so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q        <= IDLE;
      c_q            <= '0;
      d_q            <= '0;
      round_q        <= '0;
      mode_q         <= 1'b0;
      key_ready_q    <= 1'b1;
      subkey_valid_q <= 1'b0;
      subkey_q       <= '0;
      sched_done_q   <= 1'b0;
      key_err_q      <= 1'b0;
    end else begin
      sched_done_q <= 1'b0;
      key_err_q    <= 1'b0;
      case (state_q)
        IDLE: begin
          if (key_valid && !abort) begin
            if (key_bad) begin
              key_err_q <= 1'b1;
            end else begin
              c_q         <= pc1_cd[0:27];
              d_q         <= pc1_cd[28:55];
              mode_q      <= decrypt;
              round_q     <= 4'd0;
              key_ready_q <= 1'b0;
              state_q     <= SHIFT;
            end
          end
        end
        SHIFT: begin
          if (abort) begin
            key_ready_q <= 1'b1;
            state_q     <= IDLE;
          end else begin
            c_q            <= c_d;
            d_q            <= d_d;
            subkey_q       <= pc2(c_d, d_d);
            subkey_valid_q <= 1'b1;
            state_q        <= PRESENT;
          end
        end
        PRESENT: begin
          if (abort) begin
            subkey_valid_q <= 1'b0;
            key_ready_q    <= 1'b1;
            state_q        <= IDLE;
          end else if (subkey_ready) begin
            subkey_valid_q <= 1'b0;
            if (round_q == 4'd15) begin
              sched_done_q <= 1'b1;
              key_ready_q  <= 1'b1;
              state_q      <= IDLE;
            end else begin
              round_q <= round_q + 4'd1;
              state_q <= SHIFT;
            end
          end
        end
        default: begin
          subkey_valid_q <= 1'b0;
          key_ready_q    <= 1'b1;
          state_q        <= IDLE;
        end
      endcase
    end
  end

  assign key_ready    = key_ready_q;
  assign subkey       = subkey_q;
  assign round        = round_q;
  assign subkey_valid = subkey_valid_q;
  assign sched_done   = sched_done_q;
  assign key_err      = key_err_q;

endmodule

// File: tb/tb_des_key_scheduler.sv
// Scoreboard bench for des_key_scheduler against the published subkeys of
// the classic key 0x133457799BBCDFF1, plus a parity-checking instance.
module tb_des_key_scheduler;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        n_rst;
  logic [0:63] key_in;
  logic        decrypt, key_valid, abort, subkey_ready;
  logic        key_ready, subkey_valid, sched_done, key_err;
  logic [0:47] subkey;
  logic [3:0]  round;

  logic [0:63] p_key_in;
  logic        p_decrypt, p_key_valid, p_abort, p_subkey_ready;
  logic        p_key_ready, p_subkey_valid, p_sched_done, p_key_err;
  logic [0:47] p_subkey;
  logic [3:0]  p_round;

  des_key_scheduler #(.PARITY_CHECK(0)) u_dut (
    .clk(clk), .n_rst(n_rst), .key_in(key_in), .decrypt(decrypt),
    .key_valid(key_valid), .key_ready(key_ready), .abort(abort),
    .subkey(subkey), .round(round), .subkey_valid(subkey_valid),
    .subkey_ready(subkey_ready), .sched_done(sched_done), .key_err(key_err)
  );

  des_key_scheduler #(.PARITY_CHECK(1)) u_dut_par (
    .clk(clk), .n_rst(n_rst), .key_in(p_key_in), .decrypt(p_decrypt),
    .key_valid(p_key_valid), .key_ready(p_key_ready), .abort(p_abort),
    .subkey(p_subkey), .round(p_round), .subkey_valid(p_subkey_valid),
    .subkey_ready(p_subkey_ready), .sched_done(p_sched_done), .key_err(p_key_err)
  );

  localparam logic [63:0] KEY = 64'h133457799BBCDFF1;

  // K1..K16 for KEY, from the standard worked DES example.
  localparam logic [47:0] KS [16] = '{
    48'h1B02EFFC7072, 48'h79AED9DBC9E5, 48'h55FC8A42CF99, 48'h72ADD6DB351D,
    48'h7CEC07EB53A8, 48'h63A53E507B2F, 48'hEC84B7F618BC, 48'hF78A3AC13BFB,
    48'hE0DBEBEDE781, 48'hB1F347BA464F, 48'h215FD3DED386, 48'h7571F59467E9,
    48'h97C5D1FABA41, 48'h5F43B7F2E73A, 48'hBF918D3D3F0A, 48'hCB3D8B0E17F5
  };

  typedef struct packed {
    logic [3:0]  rnd;
    logic [47:0] sk;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_pass = 0;
  int   cycle_cnt = 0;
  int   done_cnt = 0;
  int   done_cyc = 0;
  int   accept_cyc = 0;
  int   d0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, want);
  endtask

  always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

  always @(negedge clk) begin
    if (n_rst && subkey_valid && subkey_ready && !abort) begin
      if (exp_q.size() == 0) begin
        check("sb_unexpected_handshake", 64'(exp_q.size()), 64'd1);
      end else begin
        mon_e = exp_q.pop_front();
        check("sb_round", 64'(round), 64'(mon_e.rnd));
        check("sb_subkey", 64'(subkey), 64'(mon_e.sk));
      end
    end
    if (n_rst && sched_done) begin
      done_cnt++;
      done_cyc = cycle_cnt;
    end
  end

  task automatic wait_key_ready();
    int n = 0;
    @(negedge clk);
    while (!key_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!key_ready) check("key_ready_timeout", 64'(key_ready), 64'd1);
  endtask

  task automatic send_key(input logic [63:0] key, input logic dec);
    wait_key_ready();
    @(posedge clk); #1;
    key_in    = key;
    decrypt   = dec;
    key_valid = 1'b1;
    for (int r = 0; r < 16; r++)
      exp_q.push_back('{rnd: 4'(r), sk: dec ? KS[15-r] : KS[r]});
    @(posedge clk); #1;
    key_valid  = 1'b0;
    accept_cyc = cycle_cnt;
  endtask

  // Wait for the SHIFT cycle of round r (round==r, nothing presented yet).
  task automatic wait_shift(input int r);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(round == 4'(r) && !subkey_valid && !key_ready) && n < 100);
    check($sformatf("wait_shift_%0d", r), 64'(round), 64'(r));
  endtask

  task automatic wait_done(input string tag, input int exp_lat);
    int start = done_cnt;
    int n = 0;
    while (done_cnt == start && n < 200) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_done_count"}, 64'(done_cnt - start), 64'd1);
    check({tag, "_latency"}, 64'(done_cyc - accept_cyc), 64'(exp_lat));
    check({tag, "_sb_drained"}, 64'(exp_q.size()), 64'd0);
    @(negedge clk);
    check({tag, "_done_pulse_width"}, 64'(sched_done), 64'd0);
  endtask

  task automatic p_send(input logic [63:0] key);
    @(posedge clk); #1;
    p_key_in    = key;
    p_key_valid = 1'b1;
    @(posedge clk); #1;
    p_key_valid = 1'b0;
  endtask

  task automatic p_reject(input string tag, input logic [63:0] key);
    p_send(key);
    @(negedge clk);
    check({tag, "_key_err"}, 64'(p_key_err), 64'd1);
    check({tag, "_key_ready"}, 64'(p_key_ready), 64'd1);
    @(negedge clk);
    check({tag, "_key_err_pulse"}, 64'(p_key_err), 64'd0);
    check({tag, "_no_subkey"}, 64'(p_subkey_valid), 64'd0);
  endtask

  task automatic p_accept(input string tag, input logic [63:0] key, input logic [47:0] k1);
    p_send(key);
    @(negedge clk);
    check({tag, "_no_key_err"}, 64'(p_key_err), 64'd0);
    check({tag, "_busy"}, 64'(p_key_ready), 64'd0);
    @(negedge clk);
    check({tag, "_valid"}, 64'(p_subkey_valid), 64'd1);
    check({tag, "_k1"}, 64'(p_subkey), 64'(k1));
    @(posedge clk); #1 p_abort = 1'b1;
    @(posedge clk); #1 p_abort = 1'b0;
    @(negedge clk);
    check({tag, "_aborted"}, 64'(p_key_ready), 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end

  initial begin
    n_rst = 1'b0;
    key_in = '0; decrypt = 1'b0; key_valid = 1'b0; abort = 1'b0; subkey_ready = 1'b1;
    p_key_in = '0; p_decrypt = 1'b0; p_key_valid = 1'b0; p_abort = 1'b0; p_subkey_ready = 1'b1;

    #23;
    check("rst_key_ready", 64'(key_ready), 64'd1);
    check("rst_subkey_valid", 64'(subkey_valid), 64'd0);
    check("rst_sched_done", 64'(sched_done), 64'd0);
    check("rst_key_err", 64'(key_err), 64'd0);
    check("rst_subkey", 64'(subkey), 64'd0);
    check("rst_round", 64'(round), 64'd0);
    @(negedge clk);
    n_rst = 1'b1;

    // Encrypt with the round engine always ready.
    send_key(KEY, 1'b0);
    @(negedge clk);
    check("enc_t1_valid", 64'(subkey_valid), 64'd0);
    check("enc_t1_key_ready", 64'(key_ready), 64'd0);
    @(negedge clk);
    check("enc_t2_valid", 64'(subkey_valid), 64'd1);
    wait_done("enc", 32);
    check("enc_idle_key_ready", 64'(key_ready), 64'd1);

    // Decrypt: exact reverse order.
    send_key(KEY, 1'b1);
    wait_done("dec", 32);

    // Back-pressure at round 3 for five cycles.
    send_key(KEY, 1'b0);
    wait_shift(3);
    @(posedge clk); #1 subkey_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_valid", 64'(subkey_valid), 64'd1);
      check("bp_round", 64'(round), 64'd3);
      check("bp_subkey", 64'(subkey), 64'(KS[3]));
    end
    @(posedge clk); #1 subkey_ready = 1'b1;
    wait_done("bp", 37);

    // Abort together with subkey_ready at round 7.
    d0 = done_cnt;
    send_key(KEY, 1'b0);
    wait_shift(7);
    @(posedge clk); #1 abort = 1'b1;
    @(posedge clk); #1 abort = 1'b0;
    @(negedge clk);
    check("ab_valid_drop", 64'(subkey_valid), 64'd0);
    check("ab_key_ready", 64'(key_ready), 64'd1);
    check("ab_sb_remaining", 64'(exp_q.size()), 64'd9);
    exp_q.delete();
    repeat (3) @(negedge clk);
    check("ab_no_done", 64'(done_cnt - d0), 64'd0);
    send_key(KEY, 1'b0);
    wait_done("ab_new", 32);

    // abort in IDLE beats a simultaneous key_valid.
    @(posedge clk); #1;
    key_in = KEY; key_valid = 1'b1; abort = 1'b1;
    @(posedge clk); #1;
    key_valid = 1'b0; abort = 1'b0;
    @(negedge clk);
    check("idle_abort_key_ready", 64'(key_ready), 64'd1);
    @(negedge clk);
    check("idle_abort_no_valid", 64'(subkey_valid), 64'd0);

    // Parity-checking instance.
    p_reject("par_last_byte_even", 64'h133457799BBCDFF0);
    p_reject("par_first_byte_even", 64'h123457799BBCDFF1);
    p_accept("par_ok_key", KEY, KS[0]);
    p_accept("par_weak_key", 64'h0101010101010101, 48'h0);

    // Asynchronous reset in the middle of round 9.
    d0 = done_cnt;
    send_key(KEY, 1'b0);
    wait_shift(9);
    @(posedge clk); #1;
    n_rst = 1'b0;
    key_in = KEY; key_valid = 1'b1;
    #1;
    check("mrst_valid", 64'(subkey_valid), 64'd0);
    check("mrst_key_ready", 64'(key_ready), 64'd1);
    check("mrst_round", 64'(round), 64'd0);
    exp_q.delete();
    @(posedge clk); @(posedge clk); #2;
    key_valid = 1'b0;
    @(negedge clk);
    n_rst = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("mrst_no_accept", 64'(subkey_valid), 64'd0);
    end
    check("mrst_key_ready_after", 64'(key_ready), 64'd1);
    check("mrst_no_done", 64'(done_cnt - d0), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
